// File: rtl/srca_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : srca_operand_stage
//  Description : Registered ALU source-A operand stage on the ID->EX boundary.
//                Selects rs1 / U-type immediate / ~rs1 / PC, with EX/MEM
//                forwarding onto rs1. Also detects load-use hazards and stalls
//                ID while they last. The result is captured in a valid/ready
//                pipeline register that can be flushed.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST_N            clock (rising edge), synchronous active-low reset
//    flush                 kill the captured op and the incoming op
//    in_valid / in_ready   ID-side handshake (in_ready is combinational)
//    alu_srcA              00 rs1, 01 U_Type, 10 ~rs1, 11 pc
//    rs1_addr, rs1         source register index and register-file data
//    U_Type, pc            U-type immediate and PC of the ID op
//    ex_we, ex_is_load,
//    ex_rd, ex_data        EX-stage writer info (loads cannot forward)
//    mem_we, mem_rd,
//    mem_data              MEM-stage writer info
//    out_valid / out_ready EX-side handshake
//    srcA                  registered source-A operand
//    stall_cnt             saturating count of load-use stall cycles
// ============================================================================
module srca_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_srcA,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [XLEN-1:0]    rs1,
    input  logic [XLEN-1:0]    U_Type,
    input  logic [XLEN-1:0]    pc,
    input  logic               ex_we,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    srcA,
    output logic [15:0]        stall_cnt
);

    localparam logic [1:0]  c_sel_rs1   = 2'b00;
    localparam logic [1:0]  c_sel_utype = 2'b01;
    localparam logic [1:0]  c_sel_nrs1  = 2'b10;
    localparam logic [1:0]  c_sel_pc    = 2'b11;
    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic               r_out_valid;
    logic [XLEN-1:0]    r_srcA;
    logic [15:0]        r_stall_cnt;

    logic               w_uses_rs1;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic               w_load_use;
    logic [XLEN-1:0]    w_mux;
    logic               w_accept;

    assign w_uses_rs1 = (alu_srcA == c_sel_rs1) || (alu_srcA == c_sel_nrs1);

    generate
        if (FWD_EN) begin : g_fwd_on
            logic w_rs1_nz;
            logic w_ex_hit;
            logic w_ex_load_hit;
            logic w_mem_hit;

            // x0 is hardwired zero, so it never takes a bypass or stalls.
            assign w_rs1_nz      = (rs1_addr != '0);
            // A load in EX has no data yet: it cannot forward, it stalls instead.
            assign w_ex_hit      = w_rs1_nz && ex_we && (ex_rd == rs1_addr) && !ex_is_load;
            assign w_ex_load_hit = w_rs1_nz && ex_we && (ex_rd == rs1_addr) &&  ex_is_load;
            assign w_mem_hit     = w_rs1_nz && mem_we && (mem_rd == rs1_addr);

            // EX is the younger producer, so it wins over MEM.
            assign w_fwd_rs1  = w_ex_hit  ? ex_data  :
                                w_mem_hit ? mem_data : rs1;
            assign w_load_use = in_valid && w_uses_rs1 && w_ex_load_hit;
        end else begin : g_fwd_off
            assign w_fwd_rs1  = rs1;
            assign w_load_use = 1'b0;
        end
    endgenerate

    // Inversion is applied after forwarding so ~rs1 sees the freshest value.
    always_comb begin
        w_mux = w_fwd_rs1;
        case (alu_srcA)
            c_sel_rs1:   w_mux = w_fwd_rs1;
            c_sel_utype: w_mux = U_Type;
            c_sel_nrs1:  w_mux = ~w_fwd_rs1;
            c_sel_pc:    w_mux = pc;
            default:     w_mux = w_fwd_rs1;
        endcase
    end

    // Ready is forced low while in reset so ID does not hand over an op
    // that the reset edge would discard.
    assign in_ready = RST_N && !w_load_use && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_srcA      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_srcA      <= w_mux;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                // Consumed (or bubble during a stall); srcA keeps stale data.
                r_out_valid <= 1'b0;
            end

            if (w_load_use && (r_stall_cnt != c_stall_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign srcA      = r_srcA;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
